// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator: decodes format and immediate into a 2-entry skid FIFO.
// Outputs come only from the head entry register, so decode can stall freely.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid,
  output logic             oReady,
  input  logic [31:0]      iInstr,
  input  logic [TAG_W-1:0] iTag,
  input  logic             iFlush,
  output logic             oValid,
  input  logic             iReady,
  output logic [XLEN-1:0]  oImm,
  output logic [2:0]       oFmt,
  output logic             oIllegal,
  output logic [TAG_W-1:0] oTag
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam bit RV64 = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } ent_t;

  logic [4:0]      op;
  logic            s;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0]     imm_u32;
  logic [2:0]      dec_fmt;
  logic            dec_ill;
  ent_t            dec;

  assign op = iInstr[6:2];
  assign s  = iInstr[31];

  assign imm_i = {{(XLEN-12){s}}, iInstr[31:20]};
  assign imm_s = {{(XLEN-12){s}}, iInstr[31:25], iInstr[11:7]};
  assign imm_b = {{(XLEN-13){s}}, iInstr[31], iInstr[7],
                  iInstr[30:25], iInstr[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){s}}, iInstr[31], iInstr[19:12],
                  iInstr[20], iInstr[30:21], 1'b0};
  assign imm_u32 = {iInstr[31:12], 12'b0};

  // LUI/AUIPC results are sign-extended 32-bit values on RV64
  generate
    if (XLEN == 64) begin : g_u64
      assign imm_u = {{32{s}}, imm_u32};
    end else begin : g_u32
      assign imm_u = imm_u32;
    end
  endgenerate

  always_comb begin
    dec_fmt = FMT_NONE;
    dec_ill = 1'b1;
    if (iInstr[1:0] == 2'b11) begin
      case (op)
        5'b00000, 5'b00001, 5'b00100,
        5'b11001, 5'b11100: begin
          dec_fmt = FMT_I;
          dec_ill = 1'b0;
        end
        5'b00110: if (RV64) begin
          dec_fmt = FMT_I;
          dec_ill = 1'b0;
        end
        5'b01000, 5'b01001: begin
          dec_fmt = FMT_S;
          dec_ill = 1'b0;
        end
        5'b11000: begin
          dec_fmt = FMT_B;
          dec_ill = 1'b0;
        end
        5'b00101, 5'b01101: begin
          dec_fmt = FMT_U;
          dec_ill = 1'b0;
        end
        5'b11011: begin
          dec_fmt = FMT_J;
          dec_ill = 1'b0;
        end
        5'b01100, 5'b00011, 5'b10100: dec_ill = 1'b0;
        5'b01110: if (RV64) dec_ill = 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    dec.fmt = dec_fmt;
    dec.ill = dec_ill;
    dec.tag = iTag;
    dec.imm = '0;
    case (dec_fmt)
      FMT_I:   dec.imm = imm_i;
      FMT_S:   dec.imm = imm_s;
      FMT_B:   dec.imm = imm_b;
      FMT_U:   dec.imm = imm_u;
      FMT_J:   dec.imm = imm_j;
      default: dec.imm = '0;
    endcase
  end

  ent_t       e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       acc, drn;

  assign oReady = (cnt_q != 2'd2);
  assign oValid = (cnt_q != 2'd0);
  assign acc    = iValid && oReady;
  assign drn    = oValid && iReady;

  // e0 is always the head; e1 only ever holds the second entry
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (iFlush) begin
      cnt_d = 2'd0;
    end else begin
      case ({acc, drn})
        2'b11: begin
          if (cnt_q == 2'd2) begin
            e0_d = e1_q;
            e1_d = dec;
          end else begin
            e0_d = dec;
          end
        end
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = dec;
          else               e1_d = dec;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign oImm     = e0_q.imm;
  assign oFmt     = e0_q.fmt;
  assign oIllegal = e0_q.ill;
  assign oTag     = e0_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table on XLEN=32 and XLEN=64 instances,
// plus backpressure, flush and asynchronous reset sequences.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [31:0] instr;
  logic [31:0] tag;
  logic        flush;
  logic        rdy;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32, tag32;
  logic [2:0]  fmt32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [31:0] tag64;
  logic [2:0]  fmt64;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .iCLK(clk), .iRST(rst), .iValid(vld), .oReady(rdy32),
    .iInstr(instr), .iTag(tag), .iFlush(flush),
    .oValid(vld32), .iReady(rdy), .oImm(imm32), .oFmt(fmt32),
    .oIllegal(ill32), .oTag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .iCLK(clk), .iRST(rst), .iValid(vld), .oReady(rdy64),
    .iInstr(instr), .iTag(tag), .iFlush(flush),
    .oValid(vld64), .iReady(rdy), .oImm(imm64), .oFmt(fmt64),
    .oIllegal(ill64), .oTag(tag64)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_both_ctl(input string name, input logic ev,
                              input logic er);
    chk({name, " v32"}, {63'b0, vld32}, {63'b0, ev});
    chk({name, " r32"}, {63'b0, rdy32}, {63'b0, er});
    chk({name, " v64"}, {63'b0, vld64}, {63'b0, ev});
    chk({name, " r64"}, {63'b0, rdy64}, {63'b0, er});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [63:0] i32;
    logic [63:0] i64;
    logic [2:0]  f32;
    logic [2:0]  f64;
    logic        l32;
    logic        l64;
  } vec_t;

  vec_t v[13];

  initial begin
    v[0]  = '{32'hFFF00093, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd1, 1'b0, 1'b0};
    v[1]  = '{32'hFE112E23, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 3'd2, 1'b0, 1'b0};
    v[2]  = '{32'hFE000CE3, 64'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd3, 3'd3, 1'b0, 1'b0};
    v[3]  = '{32'h001000EF, 64'h00000800, 64'h0000000000000800, 3'd5, 3'd5, 1'b0, 1'b0};
    v[4]  = '{32'h800002B7, 64'h80000000, 64'hFFFFFFFF80000000, 3'd4, 3'd4, 1'b0, 1'b0};
    v[5]  = '{32'h0000001B, 64'h00000000, 64'h0000000000000000, 3'd0, 3'd1, 1'b1, 1'b0};
    v[6]  = '{32'h00000000, 64'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b1, 1'b1};
    v[7]  = '{32'h002081B3, 64'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b0, 1'b0};
    v[8]  = '{32'h0000003B, 64'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b1, 1'b0};
    v[9]  = '{32'h80000067, 64'hFFFFF800, 64'hFFFFFFFFFFFFF800, 3'd1, 3'd1, 1'b0, 1'b0};
    v[10] = '{32'h00112423, 64'h00000008, 64'h0000000000000008, 3'd2, 3'd2, 1'b0, 1'b0};
    v[11] = '{32'h12345017, 64'h12345000, 64'h0000000012345000, 3'd4, 3'd4, 1'b0, 1'b0};
    v[12] = '{32'hFFF00090, 64'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b1, 1'b1};

    rst = 1'b1; vld = 1'b0; instr = '0; tag = '0; flush = 1'b0; rdy = 1'b1;
    #12;
    chk_both_ctl("reset", 1'b0, 1'b1);
    chk("reset imm32", {32'b0, imm32}, 64'h0);
    chk("reset imm64", imm64, 64'h0);
    chk("reset fmt", {61'b0, fmt32}, 64'h0);
    chk("reset ill", {63'b0, ill32}, 64'h0);
    chk("reset tag", {32'b0, tag32}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // streaming table, one accept per cycle with downstream always ready
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      vld = 1'b1; instr = v[i].ins; tag = 32'h100 + i;
      tick();
      chk_both_ctl($sformatf("vec%0d ctl", i), 1'b1, 1'b1);
      chk($sformatf("vec%0d imm32", i), {32'b0, imm32}, v[i].i32);
      chk($sformatf("vec%0d imm64", i), imm64, v[i].i64);
      chk($sformatf("vec%0d fmt32", i), {61'b0, fmt32}, {61'b0, v[i].f32});
      chk($sformatf("vec%0d fmt64", i), {61'b0, fmt64}, {61'b0, v[i].f64});
      chk($sformatf("vec%0d ill32", i), {63'b0, ill32}, {63'b0, v[i].l32});
      chk($sformatf("vec%0d ill64", i), {63'b0, ill64}, {63'b0, v[i].l64});
      chk($sformatf("vec%0d tag", i), {32'b0, tag32}, 64'h100 + i);
    end
    @(negedge clk);
    vld = 1'b0;
    tick();
    chk_both_ctl("drain empty", 1'b0, 1'b1);

    // backpressure: tags 1 and 2 fill the buffer, tag 3 waits
    @(negedge clk);
    rdy = 1'b0; vld = 1'b1; instr = 32'hFFF00093; tag = 32'd1;
    tick();
    chk_both_ctl("bp acc1", 1'b1, 1'b1);
    @(negedge clk);
    tag = 32'd2; instr = 32'h800002B7;
    tick();
    chk_both_ctl("bp full", 1'b1, 1'b0);
    chk("bp head tag", {32'b0, tag32}, 64'd1);
    @(negedge clk);
    tag = 32'd3; instr = 32'h002081B3;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_both_ctl($sformatf("bp hold%0d", k), 1'b1, 1'b0);
      chk($sformatf("bp hold%0d tag", k), {32'b0, tag32}, 64'd1);
      chk($sformatf("bp hold%0d imm", k), {32'b0, imm32}, 64'hFFFFFFFF);
      chk($sformatf("bp hold%0d fmt", k), {61'b0, fmt32}, 64'd1);
    end
    @(negedge clk);
    rdy = 1'b1;
    tick();
    chk_both_ctl("bp drain1", 1'b1, 1'b1);
    chk("bp tag2", {32'b0, tag32}, 64'd2);
    chk("bp tag2 imm64", imm64, 64'hFFFFFFFF80000000);
    tick();
    chk_both_ctl("bp drain2", 1'b1, 1'b1);
    chk("bp tag3", {32'b0, tag64}, 64'd3);
    chk("bp tag3 ill", {63'b0, ill32}, 64'd0);
    @(negedge clk);
    vld = 1'b0;
    tick();
    chk_both_ctl("bp empty", 1'b0, 1'b1);

    // flush while full, with a new offer in the same cycle
    @(negedge clk);
    rdy = 1'b0; vld = 1'b1; tag = 32'd5;
    tick();
    @(negedge clk);
    tag = 32'd6;
    tick();
    chk_both_ctl("fl full", 1'b1, 1'b0);
    @(negedge clk);
    flush = 1'b1; tag = 32'd9;
    tick();
    chk_both_ctl("fl after", 1'b0, 1'b1);
    @(negedge clk);
    flush = 1'b0; vld = 1'b0; rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_both_ctl($sformatf("fl quiet%0d", k), 1'b0, 1'b1);
    end

    // asynchronous reset with one entry buffered
    @(negedge clk);
    rdy = 1'b0; vld = 1'b1; instr = 32'hFE112E23; tag = 32'h55;
    tick();
    chk_both_ctl("ar one", 1'b1, 1'b1);
    vld = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_both_ctl("ar async", 1'b0, 1'b1);
    chk("ar imm", {32'b0, imm32}, 64'h0);
    chk("ar fmt", {61'b0, fmt32}, 64'h0);
    chk("ar tag", {32'b0, tag32}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rdy = 1'b1; vld = 1'b1; instr = 32'h001000EF; tag = 32'h77;
    tick();
    chk_both_ctl("ar first", 1'b1, 1'b1);
    chk("ar first tag", {32'b0, tag32}, 64'h77);
    chk("ar first imm", {32'b0, imm32}, 64'h800);
    @(negedge clk);
    vld = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
